// File: rtl/daq_frame_packer.sv
// daq_frame_packer
// Packs IN_W-bit readout FIFO words into OUT_W = IN_W*RATIO bit DAQ beats.
// Each packet is framed as HDR_BEATS header beats, a variable number of data
// beats and TRL_BEATS trailer beats. A short final data beat is filled with PAD.
// The output beat is registered. A new beat may load in the same cycle the
// held beat is consumed, so back-to-back beats have no idle cycle.
//
// Optional feature: define DAQ_PACKER_LENCHK_EN to enable the data-length check.
// When the MAX_DATA-th data beat completes without fifo_last, the block sets
// the sticky len_err flag. It then drops input words up to and including
// fifo_last, and goes on to the trailer.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   fifo_data     input word
//   fifo_valid    input word valid
//   fifo_last     final data word (only looked at during the data section)
//   fifo_ready    word accepted when fifo_valid && fifo_ready
//   daq_data      output beat; first-accepted word in the MSBs
//   daq_valid     output beat valid
//   daq_header    beat is a header beat
//   daq_trailer   beat is a trailer beat
//   daq_ready     beat consumed when daq_valid && daq_ready
//   len_err       sticky data-length error (0 unless the length check is built)
module daq_frame_packer #(
   parameter int              IN_W      = 32,
   parameter int              RATIO     = 2,
   parameter int              HDR_BEATS = 1,
   parameter int              TRL_BEATS = 1,
   parameter logic [IN_W-1:0] PAD       = '0,
   parameter int              MAX_DATA  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IN_W-1:0]       fifo_data,
   input  logic                  fifo_valid,
   input  logic                  fifo_last,
   output logic                  fifo_ready,
   output logic [IN_W*RATIO-1:0] daq_data,
   output logic                  daq_valid,
   output logic                  daq_header,
   output logic                  daq_trailer,
   input  logic                  daq_ready,
   output logic                  len_err
);

   localparam int OUT_W  = IN_W*RATIO;
   localparam int SLOT_W = $clog2(RATIO);
   localparam int BMAX   = (HDR_BEATS > TRL_BEATS) ? HDR_BEATS : TRL_BEATS;
   localparam int BC_W   = $clog2(BMAX+1);

   typedef enum logic [1:0] {
      HDR  = 2'd0,
      DATA = 2'd1,
      TRL  = 2'd2
`ifdef DAQ_PACKER_LENCHK_EN
      , DISCARD = 2'd3
`endif
   } phase_t;

   phase_t            phase_q, phase_d;
   logic [SLOT_W-1:0] slot_q;
   logic [BC_W-1:0]   bcnt_q;
   logic [OUT_W-1:0]  acc_q;
   logic [OUT_W-1:0]  beat_d;

   logic accept, last_w, slot_full, beat_done, discard, len_hit;
   logic hdr_end, trl_end;

   // Handshake and beat-completion decode
   always_comb begin
      discard = 1'b0;
`ifdef DAQ_PACKER_LENCHK_EN
      discard = (phase_q == DISCARD);
`endif
      // While dropping words no beat is produced, so input never has to wait
      fifo_ready = discard || !daq_valid || daq_ready;
      accept     = fifo_valid && fifo_ready;
      last_w     = (phase_q == DATA) && fifo_last;
      slot_full  = (slot_q == SLOT_W'(RATIO-1));
      beat_done  = accept && !discard && (slot_full || last_w);
      hdr_end    = (bcnt_q == BC_W'(HDR_BEATS-1));
      trl_end    = (bcnt_q == BC_W'(TRL_BEATS-1));
   end

   // Beat assembly: current word goes to its slot. On fifo_last the later slots
   // become PAD. Earlier slots come from the accumulator.
   always_comb begin
      beat_d = acc_q;
      for (int j = 0; j < RATIO; j++) begin
         if (SLOT_W'(j) == slot_q)
            beat_d[OUT_W-1-j*IN_W -: IN_W] = fifo_data;
         else if (last_w && (SLOT_W'(j) > slot_q))
            beat_d[OUT_W-1-j*IN_W -: IN_W] = PAD;
      end
   end

`ifdef DAQ_PACKER_LENCHK_EN
   localparam int DB_W = $clog2(MAX_DATA+1);
   logic [DB_W-1:0] dcnt_q;
   logic            len_err_q;

   always_comb
      len_hit = (phase_q == DATA) && beat_done && !last_w &&
                (dcnt_q == DB_W'(MAX_DATA-1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dcnt_q    <= '0;
         len_err_q <= 1'b0;
      end else begin
         if (phase_q != DATA)
            dcnt_q <= '0;
         else if (beat_done)
            dcnt_q <= dcnt_q + 1'b1;
         if (len_hit)
            len_err_q <= 1'b1;
      end
   end

   assign len_err = len_err_q;
`else
   assign len_hit = 1'b0;
   assign len_err = 1'b0;
`endif

   // Phase state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) phase_q <= HDR;
      else     phase_q <= phase_d;
   end

   // Phase next-state
   always_comb begin
      phase_d = phase_q;
      case (phase_q)
         HDR:  if (beat_done && hdr_end) phase_d = DATA;
         DATA: begin
            if (beat_done && last_w) phase_d = TRL;
`ifdef DAQ_PACKER_LENCHK_EN
            else if (len_hit)        phase_d = DISCARD;
`endif
         end
         TRL:  if (beat_done && trl_end) phase_d = HDR;
`ifdef DAQ_PACKER_LENCHK_EN
         DISCARD: if (accept && fifo_last) phase_d = TRL;
`endif
         default: phase_d = HDR;
      endcase
   end

   // Slot, header/trailer beat counter and partial-beat accumulator
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= '0;
         bcnt_q <= '0;
         acc_q  <= '0;
      end else begin
         if (accept && !discard)
            acc_q <= beat_d;
         if (beat_done)
            slot_q <= '0;
         else if (accept && !discard)
            slot_q <= slot_q + 1'b1;
         if (phase_d != phase_q)
            bcnt_q <= '0;
         else if (beat_done && (phase_q == HDR || phase_q == TRL))
            bcnt_q <= bcnt_q + 1'b1;
      end
   end

   // Output beat register. A completing beat always takes priority, because
   // a beat can only complete when the held beat is empty or leaving this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         daq_valid   <= 1'b0;
         daq_data    <= '0;
         daq_header  <= 1'b0;
         daq_trailer <= 1'b0;
      end else if (beat_done) begin
         daq_valid   <= 1'b1;
         daq_data    <= beat_d;
         daq_header  <= (phase_q == HDR);
         daq_trailer <= (phase_q == TRL);
      end else if (daq_ready) begin
         daq_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_daq_frame_packer.sv
module tb_daq_frame_packer;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   // RATIO=2 instance
   logic [31:0] fifo_data;
   logic        fifo_valid, fifo_last, fifo_ready;
   logic [63:0] daq_data;
   logic        daq_valid, daq_header, daq_trailer, daq_ready, len_err;

   // RATIO=4 instance
   logic [31:0]  f4_data;
   logic         f4_valid, f4_last, f4_ready;
   logic [127:0] d4_data;
   logic         d4_valid, d4_header, d4_trailer, d4_ready, d4_len_err;

   daq_frame_packer #(.IN_W(32), .RATIO(2), .HDR_BEATS(1), .TRL_BEATS(1),
                      .PAD(32'h0), .MAX_DATA(2)) u_dut (
      .clk(clk), .rst(rst),
      .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_last(fifo_last),
      .fifo_ready(fifo_ready),
      .daq_data(daq_data), .daq_valid(daq_valid), .daq_header(daq_header),
      .daq_trailer(daq_trailer), .daq_ready(daq_ready), .len_err(len_err));

   daq_frame_packer #(.IN_W(32), .RATIO(4), .HDR_BEATS(1), .TRL_BEATS(1),
                      .PAD(32'h0), .MAX_DATA(2)) u_dut4 (
      .clk(clk), .rst(rst),
      .fifo_data(f4_data), .fifo_valid(f4_valid), .fifo_last(f4_last),
      .fifo_ready(f4_ready),
      .daq_data(d4_data), .daq_valid(d4_valid), .daq_header(d4_header),
      .daq_trailer(d4_trailer), .daq_ready(d4_ready), .len_err(d4_len_err));

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [65:0]  q[$];
   int           qt[$];
   logic [129:0] q4[$];

   // Beat capture: {header, trailer, data} of every consumed beat
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (daq_valid && daq_ready) begin
         q.push_back({daq_header, daq_trailer, daq_data});
         qt.push_back(cyc);
      end
      if (d4_valid && d4_ready)
         q4.push_back({d4_header, d4_trailer, d4_data});
   end

   task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input int idx, input logic [65:0] exp);
      logic [65:0] obs;
      obs = (idx < q.size()) ? q[idx] : '1;
      chk(tag, obs, exp);
   endtask

   task automatic send(input logic [31:0] w, input logic l);
      int n;
      fifo_data  = w;
      fifo_last  = l;
      fifo_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!fifo_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!fifo_ready) chk("send_timeout", fifo_ready, 1);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      fifo_valid = 1'b0;
      fifo_last  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] A1 = 32'hA1A1_0001, A2 = 32'hA2A2_0002;
   localparam logic [31:0] D1 = 32'hD1D1_0011, D2 = 32'hD2D2_0012, D3 = 32'hD3D3_0013;
   localparam logic [31:0] T1 = 32'hF1F1_0021, T2 = 32'hF2F2_0022;

   logic [31:0] w4 [9];

   initial begin
      rst = 1'b1; daq_ready = 1'b1; fifo_valid = 1'b0; fifo_last = 1'b0; fifo_data = '0;
      d4_ready = 1'b1; f4_valid = 1'b0; f4_last = 1'b0; f4_data = '0;
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      chk("rst_valid",   daq_valid,   0);
      chk("rst_data",    daq_data,    0);
      chk("rst_header",  daq_header,  0);
      chk("rst_trailer", daq_trailer, 0);
      chk("rst_len_err", len_err,     0);
      chk("rst_ready",   fifo_ready,  1);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic packet
      q.delete();
      send(A1, 0); send(A2, 0); send(D1, 0); send(D2, 0); send(D3, 1);
      send(T1, 0); send(T2, 0);
      idle(3);
      chk("basic_count", q.size(), 4);
      chk_beat("basic_hdr",  0, {2'b10, A1, A2});
      chk_beat("basic_d12",  1, {2'b00, D1, D2});
      chk_beat("basic_pad",  2, {2'b00, D3, 32'h0});
      chk_beat("basic_trl",  3, {2'b01, T1, T2});

      // Output stall on the header beat
      q.delete();
      daq_ready = 1'b0;
      send(A1, 0); send(A2, 0);
      fifo_data = D1; fifo_last = 1'b0; fifo_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid",  daq_valid,  1);
         chk("stall_data",   daq_data,   {A1, A2});
         chk("stall_header", daq_header, 1);
         chk("stall_ready",  fifo_ready, 0);
         @(posedge clk); #1;
      end
      daq_ready = 1'b1;
      send(D1, 0); send(D2, 0); send(D3, 1); send(T1, 0); send(T2, 0);
      idle(3);
      chk("stall_count", q.size(), 4);
      chk_beat("stall_hdr", 0, {2'b10, A1, A2});
      chk_beat("stall_d12", 1, {2'b00, D1, D2});
      chk_beat("stall_pad", 2, {2'b00, D3, 32'h0});
      chk_beat("stall_trl", 3, {2'b01, T1, T2});

      // Back-to-back packets, input always valid
      q.delete(); qt.delete();
      send(A1, 0); send(A2, 0); send(D1, 0); send(D2, 1); send(T1, 0); send(T2, 0);
      send(32'hA3A3_0003, 0); send(32'hA4A4_0004, 0); send(D3, 1);
      send(32'hF3F3_0023, 0); send(32'hF4F4_0024, 0);
      idle(3);
      chk("b2b_count", q.size(), 6);
      chk_beat("b2b_d12",  1, {2'b00, D1, D2});
      chk_beat("b2b_trl1", 2, {2'b01, T1, T2});
      chk_beat("b2b_hdr2", 3, {2'b10, 32'hA3A3_0003, 32'hA4A4_0004});
      chk_beat("b2b_pad",  4, {2'b00, D3, 32'h0});
      chk_beat("b2b_trl2", 5, {2'b01, 32'hF3F3_0023, 32'hF4F4_0024});
      chk("b2b_gap", (qt.size() >= 4) ? qt[3] - qt[2] : -1, 2);

      // Reset mid-DATA with D1 in the partial beat
      send(A1, 0); send(A2, 0); send(D1, 0);
      fifo_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_valid",   daq_valid,   0);
      chk("mrst_data",    daq_data,    0);
      chk("mrst_header",  daq_header,  0);
      chk("mrst_trailer", daq_trailer, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      send(A1, 0); send(A2, 0); send(D2, 1); send(T1, 0); send(T2, 0);
      idle(3);
      chk("mrst_count", q.size(), 3);
      chk_beat("mrst_hdr", 0, {2'b10, A1, A2});
      chk_beat("mrst_pad", 1, {2'b00, D2, 32'h0});
      chk_beat("mrst_trl", 2, {2'b01, T1, T2});

`ifdef DAQ_PACKER_LENCHK_EN
      // Length check with MAX_DATA=2: words 5..7 dropped
      q.delete();
      send(A1, 0); send(A2, 0);
      for (int i = 1; i <= 7; i++) send(32'hDA00_0000 + 32'(i), (i == 7));
      send(T1, 0); send(T2, 0);
      idle(3);
      chk("len_count", q.size(), 4);
      chk_beat("len_hdr", 0, {2'b10, A1, A2});
      chk_beat("len_d12", 1, {2'b00, 32'hDA00_0001, 32'hDA00_0002});
      chk_beat("len_d34", 2, {2'b00, 32'hDA00_0003, 32'hDA00_0004});
      chk_beat("len_trl", 3, {2'b01, T1, T2});
      chk("len_err_set", len_err, 1);
`else
      chk("len_err_tied", len_err, 0);
`endif

      // RATIO=4: single-word data section gives one padded beat
      w4 = '{32'h4101, 32'h4102, 32'h4103, 32'h4104, 32'h4D01,
             32'h4F01, 32'h4F02, 32'h4F03, 32'h4F04};
      q4.delete();
      for (int i = 0; i < 9; i++) begin
         f4_data = w4[i]; f4_last = (i == 4); f4_valid = 1'b1;
         @(negedge clk);
         chk("r4_ready", f4_ready, 1);
         @(posedge clk); #1;
      end
      f4_valid = 1'b0; f4_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("r4_count", q4.size(), 3);
      chk("r4_hdr",  (q4.size() > 0) ? q4[0] : '1,
          {2'b10, 32'h4101, 32'h4102, 32'h4103, 32'h4104});
      chk("r4_pad",  (q4.size() > 1) ? q4[1] : '1,
          {2'b00, 32'h4D01, 32'h0, 32'h0, 32'h0});
      chk("r4_trl",  (q4.size() > 2) ? q4[2] : '1,
          {2'b01, 32'h4F01, 32'h4F02, 32'h4F03, 32'h4F04});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
